// File: rtl/foosball_pkg.sv
// Shared types and constants for the foosball ball kinematics.
// Holds ball FSM states, serve directions and score limit.
package foosball_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    GOAL
  } ball_state_t;

  localparam logic       DIR_LEFT  = 1'b0;
  localparam logic       DIR_RIGHT = 1'b1;
  localparam logic [3:0] SCORE_MAX = 4'd9;

endpackage

// File: rtl/tick_edge_sync.sv
// Synchronises the divided game clock and turns each
// rising edge into a one-cycle step strobe.
module tick_edge_sync (
  input  logic clk_in,
  input  logic reset,
  input  logic tick_in,
  output logic step
);

  logic r_sync1;
  logic r_sync2;
  logic r_sync3;

  // two-flop synchroniser plus one delay flop for edge detection
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= tick_in;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign step = r_sync2 & ~r_sync3;

endmodule

// File: rtl/ball_motion.sv
// Ball kinematics: diagonal motion, wall bounce, rod deflection, goals.
// Optional goal counters are built when SCORE_CNT_EN is defined.
module ball_motion
  import foosball_pkg::*;
#(
  parameter int FIELD_W   = 160,
  parameter int FIELD_H   = 120,
  parameter int GOAL_HOLD = 8
) (
  input  logic                       clk_in,
  input  logic                       reset,
  input  logic                       tick_in,
  input  logic                       serve,
  input  logic                       serve_dir,
  input  logic                       rod_hit,
  output logic [$clog2(FIELD_W)-1:0] ball_x,
  output logic [$clog2(FIELD_H)-1:0] ball_y,
  output logic                       running,
  output logic                       goal_l,
  output logic                       goal_r,
  output logic [3:0]                 score_l,
  output logic [3:0]                 score_r
);

  localparam int XW = $clog2(FIELD_W);
  localparam int YW = $clog2(FIELD_H);
  localparam int HW = (GOAL_HOLD > 1) ? $clog2(GOAL_HOLD) : 1;

  localparam logic [XW-1:0] X_MID  = XW'(FIELD_W / 2);
  localparam logic [YW-1:0] Y_MID  = YW'(FIELD_H / 2);
  localparam logic [XW-1:0] X_MAX  = XW'(FIELD_W - 1);
  localparam logic [YW-1:0] Y_MAX  = YW'(FIELD_H - 1);
  localparam logic [HW-1:0] H_LAST = HW'(GOAL_HOLD - 1);

  logic w_step;

  ball_state_t   r_state, w_state;
  logic [XW-1:0] r_x, w_x;
  logic [YW-1:0] r_y, w_y;
  logic          r_dx, w_dx;
  logic          r_dy, w_dy;
  logic [HW-1:0] r_hold, w_hold;
  logic          r_gl, w_gl;
  logic          r_gr, w_gr;

  tick_edge_sync u_sync (
    .clk_in  (clk_in),
    .reset   (reset),
    .tick_in (tick_in),
    .step    (w_step)
  );

  // state and ball registers
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_x     <= X_MID;
      r_y     <= Y_MID;
      r_dx    <= DIR_RIGHT;
      r_dy    <= 1'b1;
      r_hold  <= '0;
      r_gl    <= 1'b0;
      r_gr    <= 1'b0;
    end else begin
      r_state <= w_state;
      r_x     <= w_x;
      r_y     <= w_y;
      r_dx    <= w_dx;
      r_dy    <= w_dy;
      r_hold  <= w_hold;
      r_gl    <= w_gl;
      r_gr    <= w_gr;
    end
  end

  // next state: serve, per-step motion, goal hold and recentre
  always_comb begin
    w_state = r_state;
    w_x     = r_x;
    w_y     = r_y;
    w_dx    = r_dx;
    w_dy    = r_dy;
    w_hold  = r_hold;
    w_gl    = 1'b0;
    w_gr    = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_x = X_MID;
        w_y = Y_MID;
        if (serve) begin
          w_state = RUN;
          w_dx    = serve_dir;
          w_dy    = 1'b1;
        end
      end
      RUN: begin
        if (w_step) begin
          w_dx = r_dx ^ rod_hit;
          if (r_dy && r_y == Y_MAX) begin
            w_dy = 1'b0;
            w_y  = r_y - YW'(1);
          end else if (!r_dy && r_y == '0) begin
            w_dy = 1'b1;
            w_y  = r_y + YW'(1);
          end else if (r_dy) begin
            w_y = r_y + YW'(1);
          end else begin
            w_y = r_y - YW'(1);
          end
          w_x = w_dx ? r_x + XW'(1) : r_x - XW'(1);
          if (w_x == '0) begin
            w_gl    = 1'b1;
            w_state = GOAL;
            w_hold  = '0;
          end else if (w_x == X_MAX) begin
            w_gr    = 1'b1;
            w_state = GOAL;
            w_hold  = '0;
          end
        end
      end
      GOAL: begin
        if (w_step) begin
          if (r_hold == H_LAST) begin
            w_x     = X_MID;
            w_y     = Y_MID;
            w_dy    = 1'b1;
            w_hold  = '0;
            w_state = IDLE;
          end else begin
            w_hold = r_hold + HW'(1);
          end
        end
      end
      default: w_state = IDLE;
    endcase
  end

`ifdef SCORE_CNT_EN
  logic [3:0] r_sl;
  logic [3:0] r_sr;

  // saturating goal counters, updated with the goal pulse
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_sl <= '0;
      r_sr <= '0;
    end else begin
      if (w_gl && r_sl != SCORE_MAX) r_sl <= r_sl + 4'd1;
      if (w_gr && r_sr != SCORE_MAX) r_sr <= r_sr + 4'd1;
    end
  end

  assign score_l = r_sl;
  assign score_r = r_sr;
`else
  assign score_l = 4'd0;
  assign score_r = 4'd0;
`endif

  assign ball_x  = r_x;
  assign ball_y  = r_y;
  assign running = (r_state == RUN);
  assign goal_l  = r_gl;
  assign goal_r  = r_gr;

endmodule

// File: tb/tb_ball_motion.sv
// Self-checking bench for ball_motion with a queued reference model.
// Honours SCORE_CNT_EN for the expected score values.
module tb_ball_motion;

  logic       clk = 0;
  logic       reset = 1;
  logic       tick_in = 0;
  logic       serve = 0;
  logic       serve_dir = 0;
  logic       rod_hit = 0;
  logic [7:0] ball_x;
  logic [6:0] ball_y;
  logic       running;
  logic       goal_l;
  logic       goal_r;
  logic [3:0] score_l;
  logic [3:0] score_r;

  ball_motion dut (
    .clk_in    (clk),
    .reset     (reset),
    .tick_in   (tick_in),
    .serve     (serve),
    .serve_dir (serve_dir),
    .rod_hit   (rod_hit),
    .ball_x    (ball_x),
    .ball_y    (ball_y),
    .running   (running),
    .goal_l    (goal_l),
    .goal_r    (goal_r),
    .score_l   (score_l),
    .score_r   (score_r)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int run;
    int gl;
    int gr;
    int sl;
    int sr;
  } exp_t;

  exp_t sbq[$];

  int n_chk = 0;
  int n_pass = 0;
  int seen_gl, seen_gr;

  int m_x, m_y, m_dx, m_dy, m_st, m_hold, m_sl, m_sr;

  task automatic model_reset();
    m_x = 80; m_y = 60; m_dx = 1; m_dy = 1;
    m_st = 0; m_hold = 0; m_sl = 0; m_sr = 0;
  endtask

  function automatic int bump(input int s);
`ifdef SCORE_CNT_EN
    return (s < 9) ? s + 1 : s;
`else
    return s;
`endif
  endfunction

  task automatic model_step(input logic rod, output exp_t e);
    int gl = 0;
    int gr = 0;
    if (m_st == 1) begin
      if (rod) m_dx = -m_dx;
      if (m_dy == 1 && m_y == 119) begin
        m_dy = -1; m_y = 118;
      end else if (m_dy == -1 && m_y == 0) begin
        m_dy = 1; m_y = 1;
      end else begin
        m_y = m_y + m_dy;
      end
      m_x = m_x + m_dx;
      if (m_x == 0) begin
        gl = 1; m_sl = bump(m_sl); m_st = 2; m_hold = 0;
      end else if (m_x == 159) begin
        gr = 1; m_sr = bump(m_sr); m_st = 2; m_hold = 0;
      end
    end else if (m_st == 2) begin
      if (m_hold == 7) begin
        m_x = 80; m_y = 60; m_dy = 1; m_st = 0; m_hold = 0;
      end else begin
        m_hold++;
      end
    end
    e.x = m_x; e.y = m_y; e.run = (m_st == 1) ? 1 : 0;
    e.gl = gl; e.gr = gr; e.sl = m_sl; e.sr = m_sr;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    tick_in = 0; serve = 0; rod_hit = 0;
    @(negedge clk);
    reset = 0;
    model_reset();
    sbq.delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic do_serve(input logic dir);
    @(negedge clk);
    serve = 1; serve_dir = dir;
    if (m_st == 0) begin
      m_st = 1; m_dx = dir ? 1 : -1; m_dy = 1;
    end
    @(negedge clk);
    serve = 0;
  endtask

  task automatic tick(input logic rod);
    exp_t e;
    seen_gl = 0; seen_gr = 0;
    @(negedge clk);
    tick_in = 1; rod_hit = rod;
    model_step(rod, e);
    sbq.push_back(e);
    repeat (3) begin
      @(negedge clk);
      seen_gl += int'(goal_l); seen_gr += int'(goal_r);
    end
    tick_in = 0; rod_hit = 0;
    repeat (3) begin
      @(negedge clk);
      seen_gl += int'(goal_l); seen_gr += int'(goal_r);
    end
  endtask

  task automatic test_reset();
    exp_t e;
    do_reset();
    n_chk++;
    if (ball_x !== 8'd80 || ball_y !== 7'd60 || running !== 1'b0)
      $display("FAIL reset_init x=%0d y=%0d run=%0b want 80 60 0", ball_x, ball_y, running);
    else n_pass++;
    do_serve(1);
    for (int i = 0; i < 5; i++) begin
      tick(0);
      e = sbq.pop_front();
      n_chk++;
      if (ball_x !== 8'(e.x) || ball_y !== 7'(e.y) || running !== 1'(e.run))
        $display("FAIL reset_run[%0d] x=%0d y=%0d want %0d %0d", i, ball_x, ball_y, e.x, e.y);
      else n_pass++;
    end
    @(negedge clk);
    #2 reset = 1;
    #1;
    n_chk++;
    if (ball_x !== 8'd80 || ball_y !== 7'd60 || running !== 1'b0 ||
        goal_l !== 1'b0 || goal_r !== 1'b0 || score_l !== 4'd0 || score_r !== 4'd0)
      $display("FAIL reset_async x=%0d y=%0d run=%0b gl=%0b gr=%0b sl=%0d sr=%0d want 80 60 0 0 0 0 0",
               ball_x, ball_y, running, goal_l, goal_r, score_l, score_r);
    else n_pass++;
    reset = 0;
    model_reset();
    sbq.delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_serve();
    exp_t e;
    do_reset();
    do_serve(1);
    n_chk++;
    if (running !== 1'b1)
      $display("FAIL serve_run run=%0b want 1", running);
    else n_pass++;
    for (int i = 0; i < 10; i++) begin
      tick(0);
      e = sbq.pop_front();
      n_chk++;
      if (ball_x !== 8'(e.x) || ball_y !== 7'(e.y))
        $display("FAIL serve_tick[%0d] x=%0d y=%0d want %0d %0d", i, ball_x, ball_y, e.x, e.y);
      else n_pass++;
    end
    n_chk++;
    if (ball_x !== 8'd90 || ball_y !== 7'd70 || running !== 1'b1)
      $display("FAIL serve_10 x=%0d y=%0d run=%0b want 90 70 1", ball_x, ball_y, running);
    else n_pass++;
    do_serve(0);
    tick(0);
    e = sbq.pop_front();
    n_chk++;
    if (ball_x !== 8'd91 || ball_y !== 7'd71 || ball_x !== 8'(e.x))
      $display("FAIL serve_ignored x=%0d y=%0d want 91 71", ball_x, ball_y);
    else n_pass++;
  endtask

  task automatic test_wall();
    exp_t e;
    do_reset();
    do_serve(1);
    for (int i = 0; i < 60; i++) begin
      tick(0);
      e = sbq.pop_front();
      n_chk++;
      if (ball_x !== 8'(e.x) || ball_y !== 7'(e.y))
        $display("FAIL wall_tick[%0d] x=%0d y=%0d want %0d %0d", i, ball_x, ball_y, e.x, e.y);
      else n_pass++;
      if (i == 58) begin
        n_chk++;
        if (ball_y !== 7'd119)
          $display("FAIL wall_59 y=%0d want 119", ball_y);
        else n_pass++;
      end
    end
    n_chk++;
    if (ball_x !== 8'd140 || ball_y !== 7'd118)
      $display("FAIL wall_60 x=%0d y=%0d want 140 118", ball_x, ball_y);
    else n_pass++;
  endtask

  task automatic test_goal();
    exp_t e;
    do_reset();
    do_serve(1);
    for (int i = 0; i < 79; i++) begin
      tick(0);
      e = sbq.pop_front();
      n_chk++;
      if (ball_x !== 8'(e.x) || ball_y !== 7'(e.y) || seen_gr != e.gr || seen_gl != e.gl)
        $display("FAIL goal_tick[%0d] x=%0d y=%0d gr=%0d want %0d %0d %0d",
                 i, ball_x, ball_y, seen_gr, e.x, e.y, e.gr);
      else n_pass++;
    end
    n_chk++;
    if (ball_x !== 8'd159 || ball_y !== 7'd99 || seen_gr != 1 || running !== 1'b0)
      $display("FAIL goal_hit x=%0d y=%0d gr_cycles=%0d run=%0b want 159 99 1 0",
               ball_x, ball_y, seen_gr, running);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      tick(0);
      e = sbq.pop_front();
      n_chk++;
      if (ball_x !== 8'(e.x) || ball_y !== 7'(e.y) || seen_gr != 0 || running !== 1'b0)
        $display("FAIL goal_hold[%0d] x=%0d y=%0d gr=%0d want %0d %0d 0", i, ball_x, ball_y, seen_gr, e.x, e.y);
      else n_pass++;
    end
    n_chk++;
    if (ball_x !== 8'd80 || ball_y !== 7'd60)
      $display("FAIL goal_recentre x=%0d y=%0d want 80 60", ball_x, ball_y);
    else n_pass++;
    do_serve(0);
    n_chk++;
    if (running !== 1'b1)
      $display("FAIL goal_idle_serve run=%0b want 1", running);
    else n_pass++;
  endtask

  task automatic test_rod();
    exp_t e;
    do_reset();
    do_serve(1);
    for (int i = 0; i < 79; i++) begin
      tick(i == 78);
      e = sbq.pop_front();
      n_chk++;
      if (ball_x !== 8'(e.x) || ball_y !== 7'(e.y))
        $display("FAIL rod_tick[%0d] x=%0d y=%0d want %0d %0d", i, ball_x, ball_y, e.x, e.y);
      else n_pass++;
    end
    n_chk++;
    if (ball_x !== 8'd157 || seen_gr != 0 || running !== 1'b1)
      $display("FAIL rod_save x=%0d gr_cycles=%0d run=%0b want 157 0 1", ball_x, seen_gr, running);
    else n_pass++;
  endtask

  task automatic test_scores();
    exp_t e;
    int want;
    do_reset();
    for (int g = 0; g < 10; g++) begin
      do_serve(1);
      for (int i = 0; i < 87; i++) begin
        tick(0);
        e = sbq.pop_front();
        if (i == 78) begin
          n_chk++;
          if (score_r !== 4'(e.sr) || score_l !== 4'(e.sl) || seen_gr != 1)
            $display("FAIL score_model[%0d] sr=%0d sl=%0d want %0d %0d", g, score_r, score_l, e.sr, e.sl);
          else n_pass++;
        end
      end
`ifdef SCORE_CNT_EN
      want = (g + 1 < 9) ? g + 1 : 9;
`else
      want = 0;
`endif
      n_chk++;
      if (score_r !== 4'(want) || score_l !== 4'd0)
        $display("FAIL score_goal[%0d] sr=%0d sl=%0d want %0d 0", g, score_r, score_l, want);
      else n_pass++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_serve();
    test_wall();
    test_goal();
    test_rod();
    test_scores();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #20_000_000;
    $display("FAIL timeout passed=%0d total=%0d", n_pass, n_chk);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ball_motion.md
# ball_motion

Ball kinematics stage for the foosball game. It consumes the divided game clock produced by the clock divider, treating it as a level input that is synchronised and edge-detected into one-cycle step strobes. On each step it advances the ball one cell diagonally across the field, bounces it off the top and bottom walls, applies rod deflections, and detects goals. It feeds the renderer (position) and the scoreboard (goal pulses and scores).

## Interface
- FIELD_W, 160, field width in cells; x range 0..FIELD_W-1
- FIELD_H, 120, field height in cells; y range 0..FIELD_H-1
- GOAL_HOLD, 8, steps the ball stays frozen in the goal before recentring
- clk_in  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- tick_in  input  1  divided game clock from the clock divider, a level signal; each rising edge is one step
- serve  input  1  start pulse, honoured only in IDLE
- serve_dir  input  1  serve direction: 0 = left (dx=-1), 1 = right (dx=+1)
- rod_hit  input  1  rod contact, sampled on step cycles
- ball_x  output  $clog2(FIELD_W)  ball column
- ball_y  output  $clog2(FIELD_H)  ball row
- running  output  1  high in RUN
- goal_l  output  1  one-cycle pulse when the ball enters x=0
- goal_r  output  1  one-cycle pulse when the ball enters x=FIELD_W-1
- score_l, score_r  output  4  goals per side

## Operation
- Reset values: ball_x=FIELD_W/2, ball_y=FIELD_H/2, dx=+1, dy=+1 (down), state IDLE, hold counter 0, running/goal_l/goal_r 0, scores 0, synchroniser flops 0.
- Step generation: tick_in passes through a 2-flop synchroniser. step = sync2 & ~sync3, which is exactly one clk_in cycle per tick_in rising edge.
- IDLE
  - Ball is held at the centre.
  - serve=1 on any cycle (no step needed): go to RUN, dx from serve_dir, dy=+1.
- RUN, on a step cycle, evaluated in this order:
  - If rod_hit=1, negate dx first.
  - y: if dy=+1 and y=FIELD_H-1, set dy=-1 and y=y-1. If dy=-1 and y=0, set dy=+1 and y=y+1. Otherwise y=y+dy.
  - x: x=x+dx. If the new x is 0, pulse goal_l; if it is FIELD_W-1, pulse goal_r. On either goal, go to GOAL with the hold counter cleared.
  - A wall bounce and a goal on the same step both apply.
  - A rod flip on the step that would score prevents the goal.
- GOAL, on each step:
  - Increment the hold counter; ball does not move.
  - On the step where the counter equals GOAL_HOLD-1: recentre the ball, set dy=+1, go to IDLE.
- serve is ignored in RUN and GOAL. rod_hit is ignored outside RUN step cycles.
- All arithmetic is unsigned at the ball_x/ball_y widths. x and y never leave their ranges.

## Timing
- step is asserted on the 3rd clk_in rising edge after the first edge that samples tick_in high. State and position register on that same edge, so ball_x/ball_y change at the end of the step cycle.
- goal_l/goal_r are registered and are high for exactly the one cycle in which ball_x first shows 0 or FIELD_W-1. The score updates on the same edge.
- tick_in must be stable high and stable low for at least 2 clk_in cycles each.
- Reset asserted mid-operation clears everything asynchronously.
- If tick_in is high across reset release, one step fires 3 cycles after release. It is harmless because the block is in IDLE.

## Configuration
- SCORE_CNT_EN defined:
  - score_l/score_r count goals, incrementing on goal_l/goal_r.
  - Each saturates at 9.
  - Both are cleared by reset only.
- SCORE_CNT_EN undefined:
  - Counters are not built; score_l/score_r are tied to 0.
  - Goal pulses are unchanged.

## Structure
- foosball_pkg holds:
  - ball_state_t enum {IDLE, RUN, GOAL}
  - DIR_LEFT=1'b0, DIR_RIGHT=1'b1
  - SCORE_MAX=4'd9
- Sub-module tick_edge_sync: 2-flop synchroniser plus rising-edge detector. Ports clk_in, reset, tick_in, step. The rest of the block stays flat.

## Test plan
- Reset: assert reset mid-RUN -> immediately ball_x=80, ball_y=60, running=0, goal_l=goal_r=0, scores 0.
- Serve right, then 10 ticks -> ball_x=90, ball_y=70, running=1. A second serve during RUN changes nothing.
- Wall bounce: serve right, 59 ticks -> y=119; tick 60 -> y=118, x=140.
- Goal: serve right, 79 ticks, no rod_hit -> x=159, y=99, goal_r high exactly one cycle, running=0. Then 8 more ticks -> x=80, y=60, IDLE.
- Rod save: serve right, 78 ticks (x=158), then rod_hit=1 on tick 79 -> x=157, no goal_r, still RUN.
- Scores: 10 consecutive right goals -> score_r=9 with SCORE_CNT_EN; score_r=0 throughout without it.
